// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin arbiter that shares one ap_ctrl_hs ALU
// between NUM_REQ requesters. One request is granted at a time. Its operands
// are latched, issued to the ALU, and the result is returned to the same
// requester through a valid/ready handshake.
module alu_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*OP_W-1:0]       req_op,
  input  logic [NUM_REQ*DATA_W-1:0]     req_a,
  input  logic [NUM_REQ*DATA_W-1:0]     req_b,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [DATA_W-1:0]             rsp_data,
  output logic                          alu_ap_start,
  input  logic                          alu_ap_ready,
  input  logic                          alu_ap_done,
  output logic [OP_W-1:0]               alu_op,
  output logic [DATA_W-1:0]             alu_a,
  output logic [DATA_W-1:0]             alu_b,
  input  logic [DATA_W-1:0]             alu_ap_return,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e             state_q;
  logic [IDW-1:0]     rr_ptr_q;
  logic [IDW-1:0]     grant_id_q;
  logic [OP_W-1:0]    op_q;
  logic [DATA_W-1:0]  a_q;
  logic [DATA_W-1:0]  b_q;
  logic [DATA_W-1:0]  res_q;

  logic               gnt_found_s;
  logic [IDW-1:0]     gnt_idx_s;
  logic [IDW:0]       cand_s;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    cand_s      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand_s >= (IDW+1)'(NUM_REQ)) begin
        cand_s = cand_s - (IDW+1)'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!gnt_found_s && req_valid[cand_s[IDW-1:0]]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = cand_s[IDW-1:0];
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // Accept pulse toward the winning requester, only while idle.
  always_comb begin
    if (state_q == ST_IDLE && gnt_found_s) begin
      req_ready = onehot(gnt_idx_s);
    end else begin
      req_ready = '0;
    end
  end

  // Response valid toward the granted requester while in RESP.
  always_comb begin
    if (state_q == ST_RESP) begin
      rsp_valid = onehot(grant_id_q);
    end else begin
      rsp_valid = '0;
    end
  end

  assign alu_ap_start = (state_q == ST_ISSUE);
  assign busy         = (state_q != ST_IDLE);
  assign alu_op       = op_q;
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign rsp_data     = res_q;
  assign grant_id     = grant_id_q;

  // Sequencer FSM: grant, issue to ALU, wait for result, hand result back.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_found_s) begin
            op_q       <= req_op[gnt_idx_s*OP_W +: OP_W];
            a_q        <= req_a[gnt_idx_s*DATA_W +: DATA_W];
            b_q        <= req_b[gnt_idx_s*DATA_W +: DATA_W];
            grant_id_q <= gnt_idx_s;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // ap_done without ap_ready belongs to nothing we issued.
          if (alu_ap_ready) begin
            if (alu_ap_done) begin
              res_q   <= alu_ap_return;
              state_q <= ST_RESP;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (alu_ap_done) begin
            res_q   <= alu_ap_return;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready[grant_id_q]) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= (grant_id_q == LAST_ID) ? '0 : grant_id_q + IDW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed testbench for alu_share_arbiter (NUM_REQ=4, DATA_W=32, OP_W=4).
// The bench plays the ALU: either a zero-latency model (ap_ready=ap_done=start)
// or manually driven handshake lines.
module tb_alu_share_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_op;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic        alu_ap_start;
  logic        alu_ap_ready;
  logic        alu_ap_done;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_ap_return;
  logic [1:0]  grant_id;
  logic        busy;

  logic        use_model;
  logic        man_ready;
  logic        man_done;
  logic [31:0] man_ret;

  int n_total = 0;
  int n_bad   = 0;

  alu_share_arbiter #(.NUM_REQ(4), .DATA_W(32), .OP_W(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .alu_ap_start(alu_ap_start), .alu_ap_ready(alu_ap_ready),
    .alu_ap_done(alu_ap_done), .alu_op(alu_op), .alu_a(alu_a),
    .alu_b(alu_b), .alu_ap_return(alu_ap_return),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_ap_ready  = use_model ? alu_ap_start : man_ready;
  assign alu_ap_done   = use_model ? alu_ap_start : man_done;
  assign alu_ap_return = use_model ? alu_fn(alu_op, alu_a, alu_b) : man_ret;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_op[i*4 +: 4]  = op;
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [1:0]  gnt_seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [31:0] res_seq [5] = '{32'd101, 32'd202, 32'd303, 32'd404, 32'd101};

  initial begin
    reset = 1'b1; req_valid = 4'b0000; req_op = '0; req_a = '0; req_b = '0;
    rsp_ready = 4'b1111; use_model = 1'b1; man_ready = 1'b0; man_done = 1'b0;
    man_ret = 32'd0;
    do_reset();

    // Reset state
    #1;
    check_eq("rst_busy",   32'(busy), 32'd0);
    check_eq("rst_reqrdy", 32'(req_ready), 32'd0);
    check_eq("rst_rspv",   32'(rsp_valid), 32'd0);
    check_eq("rst_start",  32'(alu_ap_start), 32'd0);
    check_eq("rst_alu_a",  alu_a, 32'd0);
    check_eq("rst_alu_op", 32'(alu_op), 32'd0);
    check_eq("rst_gid",    32'(grant_id), 32'd0);

    // Single requester: req 1 ADD 5+7, zero-latency ALU
    set_req(1, 4'd0, 32'd5, 32'd7);
    req_valid = 4'b0010;
    #1;
    check_eq("t1_reqrdy_c0", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0000;
    #1;
    check_eq("t1_start_c1", 32'(alu_ap_start), 32'd1);
    check_eq("t1_a_c1",     alu_a, 32'd5);
    check_eq("t1_b_c1",     alu_b, 32'd7);
    check_eq("t1_gid_c1",   32'(grant_id), 32'd1);
    tick();
    check_eq("t1_rspv_c2",  32'(rsp_valid), 32'h2);
    check_eq("t1_data_c2",  rsp_data, 32'd12);
    tick();
    check_eq("t1_busy_c3",  32'(busy), 32'd0);

    // All four valid from reset: grant order 0,1,2,3,0, 3 cycles each
    for (int i = 0; i < 4; i++) set_req(i, 4'd0, 32'((i + 1) * 100), 32'(i + 1));
    req_valid = 4'b1111;
    do_reset();
    #1;
    for (int g = 0; g < 5; g++) begin
      check_eq("t2_reqrdy", 32'(req_ready), 32'(4'b0001 << gnt_seq[g]));
      tick();
      check_eq("t2_start",  32'(alu_ap_start), 32'd1);
      check_eq("t2_gid",    32'(grant_id), 32'(gnt_seq[g]));
      check_eq("t2_noacc",  32'(req_ready), 32'd0);
      tick();
      check_eq("t2_rspv",   32'(rsp_valid), 32'(4'b0001 << gnt_seq[g]));
      check_eq("t2_data",   rsp_data, res_seq[g]);
      tick();
    end
    req_valid = 4'b0000;
    tick();

    // Late ALU: ap_ready 2 cycles late, ap_done 3 cycles after ap_ready (rr_ptr=1)
    use_model = 1'b0;
    set_req(2, 4'd1, 32'd50, 32'd8);
    req_valid = 4'b0100;
    #1;
    check_eq("t3_reqrdy", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    check_eq("t3_start_c1", 32'(alu_ap_start), 32'd1);
    tick();
    man_done = 1'b1; man_ret = 32'hBAD;   // done without ready: must be ignored
    check_eq("t3_start_c2", 32'(alu_ap_start), 32'd1);
    tick();
    man_done = 1'b0; man_ret = 32'd0; man_ready = 1'b1;
    check_eq("t3_start_c3", 32'(alu_ap_start), 32'd1);
    tick();
    man_ready = 1'b0;
    check_eq("t3_start_c4", 32'(alu_ap_start), 32'd0);
    check_eq("t3_busy_c4",  32'(busy), 32'd1);
    check_eq("t3_a_c4",     alu_a, 32'd50);
    tick();
    check_eq("t3_busy_c5",  32'(busy), 32'd1);
    check_eq("t3_op_c5",    32'(alu_op), 32'd1);
    tick();
    man_done = 1'b1; man_ret = 32'd42;
    check_eq("t3_rspv_c6",  32'(rsp_valid), 32'd0);
    check_eq("t3_b_c6",     alu_b, 32'd8);
    tick();
    man_done = 1'b0;
    check_eq("t3_rspv_c7",  32'(rsp_valid), 32'h4);
    check_eq("t3_data_c7",  rsp_data, 32'd42);
    tick();
    check_eq("t3_idle",     32'(busy), 32'd0);

    // Backpressure on requester 3 with requester 0 pending (rr_ptr=3)
    use_model = 1'b1;
    set_req(3, 4'd3, 32'hF0F0, 32'h0FF0);
    set_req(0, 4'd2, 32'hFF, 32'h0F);
    rsp_ready = 4'b0111;
    req_valid = 4'b1001;
    #1;
    check_eq("t4_reqrdy", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b0001;
    tick();
    for (int c = 0; c < 5; c++) begin
      check_eq("t4_hold_rspv", 32'(rsp_valid), 32'h8);
      check_eq("t4_hold_data", rsp_data, 32'hFF00);
      check_eq("t4_hold_noacc", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 4'b1111;
    tick();
    check_eq("t4_next_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    tick();
    check_eq("t4_data2", rsp_data, 32'h0F);
    tick();

    // Reset mid-operation in WAIT, late ap_done afterwards (rr_ptr=1)
    use_model = 1'b0;
    set_req(1, 4'd0, 32'd9, 32'd1);
    req_valid = 4'b0010;
    #1;
    check_eq("t5_reqrdy", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0000; man_ready = 1'b1;
    tick();
    man_ready = 1'b0;
    check_eq("t5_wait_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t5_busy",  32'(busy), 32'd0);
    check_eq("t5_start", 32'(alu_ap_start), 32'd0);
    check_eq("t5_gid",   32'(grant_id), 32'd0);
    check_eq("t5_alu_a", alu_a, 32'd0);
    check_eq("t5_rdata", rsp_data, 32'd0);
    man_done = 1'b1; man_ret = 32'h1234;
    tick();
    man_done = 1'b0;
    check_eq("t5_norsp",  32'(rsp_valid), 32'd0);
    check_eq("t5_rdata2", rsp_data, 32'd0);
    check_eq("t5_busy2",  32'(busy), 32'd0);
    use_model = 1'b1;
    set_req(0, 4'd0, 32'd3, 32'd4);
    req_valid = 4'b1111;
    #1;
    check_eq("t5_rr0", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    tick();
    check_eq("t5_data", rsp_data, 32'd7);
    tick();

    // Spurious ap_done in IDLE
    use_model = 1'b0;
    man_done = 1'b1; man_ret = 32'hDEAD;
    tick();
    tick();
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_data", rsp_data, 32'd7);
    check_eq("t6_rspv", 32'(rsp_valid), 32'd0);
    check_eq("t6_start", 32'(alu_ap_start), 32'd0);
    man_done = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter and sequencer that shares one `OP_AL_32I` ALU instance between several requesters inside the `hart` top. The ALU uses the `ap_ctrl_hs` handshake. The block grants one requester at a time and latches its operands. It drives `ap_start` until `ap_ready`, captures `ap_return` on `ap_done`, and returns the result to the granted requester with a valid/ready handshake.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, from 2 to 8.
- `DATA_W`, 32: operand and result width.
- `OP_W`, 4: ALU opcode width.

Ports:
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `req_valid`  in  NUM_REQ  request pending, one bit per requester.
- `req_ready`  out  NUM_REQ  one-hot grant/accept pulse.
- `req_op`  in  NUM_REQ*OP_W  packed opcodes; requester i at `[i*OP_W +: OP_W]`.
- `req_a`, `req_b`  in  NUM_REQ*DATA_W  packed operands; requester i at `[i*DATA_W +: DATA_W]`.
- `rsp_valid`  out  NUM_REQ  one-hot result valid.
- `rsp_ready`  in  NUM_REQ  result accept, one bit per requester.
- `rsp_data`  out  DATA_W  result of the granted requester.
- `alu_ap_start`  out  1  ALU start.
- `alu_ap_ready`  in  1  ALU accepted its inputs.
- `alu_ap_done`  in  1  ALU result valid.
- `alu_op`  out  OP_W  ALU opcode input.
- `alu_a`, `alu_b`  out  DATA_W  ALU operand inputs.
- `alu_ap_return`  in  DATA_W  ALU result.
- `grant_id`  out  clog2(NUM_REQ)  index of the current or last granted requester.
- `busy`  out  1  high in every state except IDLE.

## Operation
- State machine with four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - The grant `g` is the first set bit of `req_valid` at or after `rr_ptr`, searching upward and wrapping past NUM_REQ-1 to 0.
  - If any `req_valid` is set: `req_ready[g]`=1 for that cycle only, `req_op/a/b` of slice g are latched into `op_r/a_r/b_r`, `grant_id`<=g, next state ISSUE.
  - If none is set, stay in IDLE. `req_ready` is 0.
- ISSUE:
  - `alu_ap_start`=1. `alu_op/a/b` are driven from `op_r/a_r/b_r` and stay stable through ISSUE and WAIT.
  - Hold in ISSUE until `alu_ap_ready`=1.
  - If `alu_ap_ready` and `alu_ap_done` are high in the same cycle: `res_r`<=`alu_ap_return`, next state RESP.
  - If `alu_ap_ready` is high alone, next state WAIT.
- WAIT:
  - `alu_ap_start`=0.
  - On `alu_ap_done`=1: `res_r`<=`alu_ap_return`, next state RESP.
- RESP:
  - `rsp_valid[grant_id]`=1 and `rsp_data`=`res_r`, both held until `rsp_ready[grant_id]`=1.
  - On acceptance, next state IDLE and `rr_ptr`<=(grant_id+1) mod NUM_REQ.
  - `rsp_ready` bits of other requesters are ignored.
- Fairness: a requester that holds `req_valid` is served within NUM_REQ grants.
- Request inputs are sampled only in IDLE. A requester may drop or change its request while not granted, with no effect.
- `alu_ap_done` in IDLE, RESP, or ISSUE without `alu_ap_ready` is ignored. `res_r` is not updated in those cases.
- `rsp_data` outside RESP equals `res_r`, which holds the last result. It is don't-care for checking.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `grant_id`=0, `op_r/a_r/b_r/res_r`=0, `busy`=0.
  - All of `req_ready`, `rsp_valid` and `alu_ap_start` are 0.
  - `alu_op/a/b` are 0.
- Output timing:
  - `req_ready` is combinational from state, `req_valid` and `rr_ptr`.
  - `alu_ap_start`, `rsp_valid` and `busy` are decoded from registered state.
  - `alu_op/a/b` and `rsp_data` come from registers.
  - No combinational path exists from ALU inputs to ALU outputs.
- Latency with a zero-latency ALU (ap_ready and ap_done together):
  - grant at cycle 0, ISSUE at cycle 1, RESP at cycle 2, IDLE at cycle 3 if `rsp_ready` is high.
  - Minimum repeat interval is 3 cycles per operation.
- Latency with an ALU of latency L: ISSUE until ap_ready, then WAIT for L-1 cycles, then RESP.
- Reset mid-operation:
  - Next state is IDLE and `alu_ap_start` is 0 in the cycle after `reset` is sampled.
  - A late `alu_ap_done` is ignored, and no `rsp_valid` is issued for the abandoned request.

## Test plan
- Single requester: req 1 ADD a=5, b=7; ALU with ap_ready and ap_done in the same cycle.
  - Expect `req_ready`=0010 at cycle 0, `alu_ap_start` at cycle 1, `rsp_valid`=0010 with `rsp_data`=12 at cycle 2, `busy` low at cycle 3.
- All four requesters valid from reset:
  - Grant order is 0,1,2,3,0.
  - Each requester receives its own result, 3 cycles per operation with `rsp_ready` tied high.
- ALU with ap_ready 2 cycles late and ap_done 3 cycles after ap_ready:
  - `alu_ap_start` is held for 3 cycles and `busy` stays high through WAIT.
  - `rsp_valid` appears the cycle after `ap_done`, with operands stable throughout.
- Response backpressure: `rsp_ready` held low for 5 cycles, with other requests pending.
  - `rsp_valid` and `rsp_data` stay stable, and no new `req_ready` is issued until acceptance.
- Reset mid-operation: assert `reset` in WAIT, then pulse `ap_done` after reset is released.
  - All outputs return to reset values and no `rsp_valid` is issued.
  - The next grant is requester 0 (`rr_ptr`=0).
- Spurious `alu_ap_done`=1 in IDLE with `alu_ap_return`=0xDEAD:
  - `res_r` is unchanged and no state change occurs.
